// File: rtl/te_pkg.sv
// Shared constants and the result-entry layout for the transmission-estimation
// filter scheduler.
package te_pkg;

    localparam logic [1:0] EDGE_NONE = 2'd0;
    localparam logic [1:0] EDGE_H    = 2'd1;
    localparam logic [1:0] EDGE_D    = 2'd2;
    localparam logic [1:0] EDGE_V    = 2'd3;

    localparam int OUT_FIFO_DEPTH = 3;
    localparam int CNT_W          = 2;
    localparam int PIX_W          = 8;
    localparam int FLAG_W         = 3;
    localparam int ENTRY_W        = PIX_W + FLAG_W;

    typedef struct packed {
        logic [PIX_W-1:0] pix;
        logic             sof;
        logic             eol;
        logic             eof;
    } res_entry_t;

endpackage

// File: rtl/te_out_fifo.sv
// Three-entry result FIFO; a push and a pop may land on the same edge.
// The caller's credit scheme guarantees a push never arrives when full.
module te_out_fifo
    import te_pkg::*;
(
    input  logic               clk,
    input  logic               rst,
    input  logic               push_i,
    input  logic [ENTRY_W-1:0] data_i,
    input  logic               pop_i,
    output logic [ENTRY_W-1:0] data_o,
    output logic [CNT_W-1:0]   count_o
);

    logic [ENTRY_W-1:0] mem_q [OUT_FIFO_DEPTH];
    logic [1:0]         wr_ptr_q, wr_ptr_d;
    logic [1:0]         rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0]   count_q, count_d;
    logic               pop_eff;

    localparam logic [1:0] PTR_LAST = 2'(OUT_FIFO_DEPTH - 1);

    assign pop_eff = pop_i && (count_q != '0);

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (push_i) begin
            wr_ptr_d = (wr_ptr_q == PTR_LAST) ? 2'd0 : wr_ptr_q + 2'd1;
        end
        if (pop_eff) begin
            rd_ptr_d = (rd_ptr_q == PTR_LAST) ? 2'd0 : rd_ptr_q + 2'd1;
        end
        case ({push_i, pop_eff})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            for (int i = 0; i < OUT_FIFO_DEPTH; i++) begin
                mem_q[i] <= '0;
            end
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            if (push_i) begin
                mem_q[wr_ptr_q] <= data_i;
            end
        end
    end

    assign data_o  = mem_q[rd_ptr_q];
    assign count_o = count_q;

endmodule

// File: rtl/te_filter_sched.sv
// Scheduler for the TE edge-preserving filter bank: tags beats with pixel
// coordinates, aligns edge code with the 1-cycle filter latency, selects the result.
module te_filter_sched
    import te_pkg::*;
#(
    parameter int IMG_W = 640,
    parameter int IMG_H = 480
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       in_valid,
    output logic       in_ready,
    input  logic       in_sof,
    input  logic [7:0] in_center,
    input  logic [1:0] in_edge,
    output logic       win_fire,
    input  logic [7:0] p0_res,
    input  logic [7:0] p1_res,
    input  logic [7:0] p2_res,
    input  logic [7:0] p3_res,
    output logic       out_valid,
    input  logic       out_ready,
    output logic [7:0] out_pix,
    output logic       out_sof,
    output logic       out_eol,
    output logic       out_eof
);

    localparam int COL_W = $clog2(IMG_W);
    localparam int ROW_W = $clog2(IMG_H);
    localparam logic [COL_W-1:0] COL_LAST = COL_W'(IMG_W - 1);
    localparam logic [ROW_W-1:0] ROW_LAST = ROW_W'(IMG_H - 1);

    // Both handshakes: a transfer happens on an edge where valid && ready;
    // valid never waits on ready, and in_ready depends on registers only.
    logic [COL_W-1:0] col_q, col_d, tag_col;
    logic [ROW_W-1:0] row_q, row_d, tag_row;
    logic             v1_q;
    logic [1:0]       edge1_q;
    logic [7:0]       center1_q;
    logic             border1_q, sof1_q, eol1_q, eof1_q;
    logic [CNT_W-1:0] fifo_count;
    logic [2:0]       credit_used;
    logic [7:0]       sel_pix;
    res_entry_t       push_entry;
    res_entry_t       head_entry;
    logic [ENTRY_W-1:0] head_bits;

    assign credit_used = {1'b0, fifo_count} + {2'b00, v1_q};
    assign in_ready    = credit_used < 3'(OUT_FIFO_DEPTH);
    assign win_fire    = in_valid && in_ready;

    // A start-of-frame beat forces (0,0) so the stream resynchronises.
    assign tag_col = in_sof ? '0 : col_q;
    assign tag_row = in_sof ? '0 : row_q;

    always_comb begin
        col_d = col_q;
        row_d = row_q;
        if (win_fire) begin
            if (tag_col == COL_LAST) begin
                col_d = '0;
                row_d = (tag_row == ROW_LAST) ? '0 : tag_row + 1'b1;
            end else begin
                col_d = tag_col + 1'b1;
                row_d = tag_row;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            col_q     <= '0;
            row_q     <= '0;
            v1_q      <= 1'b0;
            edge1_q   <= EDGE_NONE;
            center1_q <= '0;
            border1_q <= 1'b0;
            sof1_q    <= 1'b0;
            eol1_q    <= 1'b0;
            eof1_q    <= 1'b0;
        end else begin
            col_q <= col_d;
            row_q <= row_d;
            v1_q  <= win_fire;
            if (win_fire) begin
                edge1_q   <= in_edge;
                center1_q <= in_center;
                border1_q <= (tag_row == '0) || (tag_row == ROW_LAST) ||
                             (tag_col == '0) || (tag_col == COL_LAST);
                sof1_q    <= (tag_col == '0) && (tag_row == '0);
                eol1_q    <= (tag_col == COL_LAST);
                eof1_q    <= (tag_col == COL_LAST) && (tag_row == ROW_LAST);
            end
        end
    end

    // Filter results are valid exactly in the cycle after win_fire, i.e. while v1_q is set.
    always_comb begin
        sel_pix = center1_q;
        if (!border1_q) begin
            case (edge1_q)
                EDGE_NONE: sel_pix = p0_res;
                EDGE_H:    sel_pix = p1_res;
                EDGE_D:    sel_pix = p2_res;
                EDGE_V:    sel_pix = p3_res;
                default:   sel_pix = center1_q;
            endcase
        end
    end

    assign push_entry.pix = sel_pix;
    assign push_entry.sof = sof1_q;
    assign push_entry.eol = eol1_q;
    assign push_entry.eof = eof1_q;

    te_out_fifo u_out_fifo (
        .clk     (clk),
        .rst     (rst),
        .push_i  (v1_q),
        .data_i  (push_entry),
        .pop_i   (out_ready),
        .data_o  (head_bits),
        .count_o (fifo_count)
    );

    assign head_entry = head_bits;
    assign out_valid  = (fifo_count != '0);
    assign out_pix    = head_entry.pix;
    assign out_sof    = head_entry.sof;
    assign out_eol    = head_entry.eol;
    assign out_eof    = head_entry.eof;

endmodule

// File: tb/tb_te_filter_sched.sv
// Directed bench for te_filter_sched on a 4x4 image with a registered
// filter-bank stand-in and a scoreboard of expected result entries.
module tb_te_filter_sched;

    typedef struct packed {
        logic            sof;
        logic [7:0]      center;
        logic [1:0]      edg;
        logic [3:0][7:0] p;
        logic [7:0]      exp_pix;
        logic            exp_sof;
        logic            exp_eol;
        logic            exp_eof;
    } vec_t;

    logic       clk = 1'b0;
    logic       rst;
    logic       in_valid, in_ready, in_sof, win_fire;
    logic [7:0] in_center;
    logic [1:0] in_edge;
    logic [7:0] p0_res, p1_res, p2_res, p3_res;
    logic       out_valid, out_ready, out_sof, out_eol, out_eof;
    logic [7:0] out_pix;

    logic [3:0][7:0] p_in, p_q;
    logic [10:0] exp_q [$];
    int          acc_q [$];
    int          cyc = 0;
    int          n_tests = 0;
    int          n_fail = 0;
    int          stalls = 0;
    int          ov_run = 0;
    int          ov_max = 0;
    bit          ov_track = 0;
    bit          lat_chk = 0;
    vec_t        tbl [16];

    te_filter_sched #(.IMG_W(4), .IMG_H(4)) dut (
        .clk(clk), .rst(rst),
        .in_valid(in_valid), .in_ready(in_ready), .in_sof(in_sof),
        .in_center(in_center), .in_edge(in_edge), .win_fire(win_fire),
        .p0_res(p0_res), .p1_res(p1_res), .p2_res(p2_res), .p3_res(p3_res),
        .out_valid(out_valid), .out_ready(out_ready), .out_pix(out_pix),
        .out_sof(out_sof), .out_eol(out_eol), .out_eof(out_eof)
    );

    // Clock / filter-bank stand-in (captures the window on win_fire)
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;
    always @(posedge clk) if (win_fire) p_q <= p_in;
    assign p0_res = p_q[0];
    assign p1_res = p_q[1];
    assign p2_res = p_q[2];
    assign p3_res = p_q[3];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    function automatic vec_t mk(input logic s, input logic [7:0] c, input logic [1:0] e,
                                input logic [7:0] p0, input logic [7:0] p1,
                                input logic [7:0] p2, input logic [7:0] p3,
                                input logic [7:0] ep, input logic es, input logic el,
                                input logic ef);
        vec_t r;
        r.sof = s; r.center = c; r.edg = e;
        r.p[0] = p0; r.p[1] = p1; r.p[2] = p2; r.p[3] = p3;
        r.exp_pix = ep; r.exp_sof = es; r.exp_eol = el; r.exp_eof = ef;
        return r;
    endfunction

    // Scoreboard: every popped result must match the head of the expected queue
    always @(negedge clk) begin
        if (!rst && out_valid && out_ready) begin
            if (exp_q.size() == 0) begin
                n_tests++;
                n_fail++;
                $display("FAIL unexpected_out: got 0x%0h with nothing expected",
                         {out_pix, out_sof, out_eol, out_eof});
            end else begin
                automatic logic [10:0] e = exp_q.pop_front();
                automatic int a = acc_q.pop_front();
                check("out_beat", {21'd0, out_pix, out_sof, out_eol, out_eof}, {21'd0, e});
                if (lat_chk) check("latency", cyc - a, 1);
            end
        end
        if (ov_track) begin
            ov_run = out_valid ? ov_run + 1 : 0;
            if (ov_run > ov_max) ov_max = ov_run;
        end
    end

    // Driver: present one beat, wait (bounded) for acceptance
    task automatic send(input vec_t v);
        int w;
        w = 0;
        in_valid = 1'b1; in_sof = v.sof; in_center = v.center; in_edge = v.edg; p_in = v.p;
        while (!in_ready && w < 64) begin
            @(posedge clk); #1;
            w++;
        end
        stalls += w;
        if (!in_ready) begin
            check("send_timeout", {31'd0, in_ready}, 1);
        end else begin
            exp_q.push_back({v.exp_pix, v.exp_sof, v.exp_eol, v.exp_eof});
            @(posedge clk); #1;
            acc_q.push_back(cyc);
        end
        in_valid = 1'b0;
        in_sof   = 1'b0;
    endtask

    task automatic wait_drain(input string name);
        for (int i = 0; i < 40 && exp_q.size() != 0; i++) begin
            @(posedge clk); #1;
        end
        check(name, exp_q.size(), 0);
    endtask

    initial begin
        vec_t v;
        int   acc;
        tbl[0]  = mk(1, 8'h33, 2'd1, 8'hA0, 8'h99, 8'hC0, 8'hD0, 8'h33, 1, 0, 0);
        tbl[1]  = mk(0, 8'h11, 2'd2, 8'hA1, 8'hB1, 8'hC1, 8'hD1, 8'h11, 0, 0, 0);
        tbl[2]  = mk(0, 8'h12, 2'd3, 8'hA2, 8'hB2, 8'hC2, 8'hD2, 8'h12, 0, 0, 0);
        tbl[3]  = mk(0, 8'h13, 2'd0, 8'hA3, 8'hB3, 8'hC3, 8'hD3, 8'h13, 0, 1, 0);
        tbl[4]  = mk(0, 8'h14, 2'd1, 8'hA4, 8'hB4, 8'hC4, 8'hD4, 8'h14, 0, 0, 0);
        tbl[5]  = mk(0, 8'h15, 2'd2, 8'hA5, 8'hB5, 8'h5A, 8'hD5, 8'h5A, 0, 0, 0);
        tbl[6]  = mk(0, 8'h16, 2'd3, 8'hA6, 8'hB6, 8'hC6, 8'hD6, 8'hD6, 0, 0, 0);
        tbl[7]  = mk(0, 8'h17, 2'd0, 8'hA7, 8'hB7, 8'hC7, 8'hD7, 8'h17, 0, 1, 0);
        tbl[8]  = mk(0, 8'h18, 2'd1, 8'hA8, 8'hB8, 8'hC8, 8'hD8, 8'h18, 0, 0, 0);
        tbl[9]  = mk(0, 8'h19, 2'd0, 8'hA9, 8'hB9, 8'hC9, 8'hD9, 8'hA9, 0, 0, 0);
        tbl[10] = mk(0, 8'h1A, 2'd1, 8'hAA, 8'hBA, 8'hCA, 8'hDA, 8'hBA, 0, 0, 0);
        tbl[11] = mk(0, 8'h1B, 2'd2, 8'hAB, 8'hBB, 8'hCB, 8'hDB, 8'h1B, 0, 1, 0);
        tbl[12] = mk(0, 8'h1C, 2'd3, 8'hAC, 8'hBC, 8'hCC, 8'hDC, 8'h1C, 0, 0, 0);
        tbl[13] = mk(0, 8'h1D, 2'd0, 8'hAD, 8'hBD, 8'hCD, 8'hDD, 8'h1D, 0, 0, 0);
        tbl[14] = mk(0, 8'h1E, 2'd1, 8'hAE, 8'hBE, 8'hCE, 8'hDE, 8'h1E, 0, 0, 0);
        tbl[15] = mk(0, 8'h1F, 2'd2, 8'hAF, 8'hBF, 8'hCF, 8'hDF, 8'h1F, 0, 1, 1);

        // Reset
        rst = 1'b1; in_valid = 1'b0; in_sof = 1'b0; in_center = '0; in_edge = '0;
        p_in = '0; out_ready = 1'b1;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        check("reset_out_valid", {31'd0, out_valid}, 0);
        check("reset_in_ready",  {31'd0, in_ready},  1);
        check("reset_win_fire",  {31'd0, win_fire},  0);

        // Full frame at full rate: exact latency, no stalls, continuous output
        lat_chk = 1; ov_track = 1; ov_run = 0; ov_max = 0; stalls = 0;
        for (int i = 0; i < 16; i++) send(tbl[i]);
        wait_drain("frame_drain");
        ov_track = 0; lat_chk = 0;
        check("thru_stalls", stalls, 0);
        check("thru_out_valid_run", ov_max, 16);

        // Backpressure: out_ready low with continuous in_valid
        out_ready = 1'b0;
        acc = 0;
        for (int c = 0; c < 8; c++) begin
            v = tbl[acc];
            in_valid = 1'b1; in_sof = v.sof; in_center = v.center; in_edge = v.edg; p_in = v.p;
            if (in_ready) begin
                exp_q.push_back({v.exp_pix, v.exp_sof, v.exp_eol, v.exp_eof});
                acc_q.push_back(cyc);
                acc++;
            end
            @(posedge clk); #1;
        end
        check("bp_accepts", acc, 3);
        check("bp_in_ready", {31'd0, in_ready}, 0);
        check("bp_win_fire", {31'd0, win_fire}, 0);
        check("bp_out_valid", {31'd0, out_valid}, 1);
        in_valid = 1'b0; in_sof = 1'b0;
        out_ready = 1'b1;
        wait_drain("bp_drain");
        for (int i = 3; i < 16; i++) send(tbl[i]);
        wait_drain("bp_frame_drain");

        // Resync: sof accepted at counter (2,1); next beat becomes (1,0)
        for (int i = 0; i < 6; i++) send(tbl[i]);
        send(mk(1, 8'h44, 2'd2, 8'hA0, 8'hB0, 8'h77, 8'hD0, 8'h44, 1, 0, 0));
        for (int i = 1; i < 16; i++) send(tbl[i]);
        wait_drain("resync_drain");

        // Mid-frame reset with two entries queued
        out_ready = 1'b0;
        send(tbl[0]);
        send(tbl[1]);
        @(posedge clk); #1;
        check("pre_rst_out_valid", {31'd0, out_valid}, 1);
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        exp_q.delete();
        acc_q.delete();
        check("mid_rst_out_valid", {31'd0, out_valid}, 0);
        check("mid_rst_in_ready",  {31'd0, in_ready},  1);
        send(mk(0, 8'h55, 2'd3, 8'hA0, 8'hB0, 8'hC0, 8'h66, 8'h55, 1, 0, 0));
        out_ready = 1'b1;
        wait_drain("mid_rst_drain");

        repeat (3) @(posedge clk);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/te_filter_sched.md
Name: te_filter_sched

Overview:
Scheduler for the Transmission Estimation edge-preserving filter bank (four 3x3 filters P0..P3, each with a 1-cycle registered-input latency and no clock enable). It accepts window beats from the window generator, tracks pixel coordinates, and aligns the edge-direction code with the filter latency. It selects the filter result, or the raw centre pixel at image borders, and buffers results so downstream backpressure never drops a value already in flight through the non-stallable filters.

Parameters:
IMG_W, 640, pixels per line (>=3)
IMG_H, 480, lines per frame (>=3)

Ports:
clk  in  1  system clock
rst  in  1  reset
in_valid  in  1  window beat valid (window generator)
in_ready  out  1  scheduler can accept a beat
in_sof  in  1  beat is pixel (0,0) of a frame
in_center  in  8  window centre pixel (in5 of the filter bank)
in_edge  in  2  edge code: 0 none->P0, 1 horizontal->P1, 2 diagonal->P2, 3 vertical->P3
win_fire  out  1  in_valid && in_ready; filter bank captures the window this edge
p0_res, p1_res, p2_res, p3_res  in  8 each  filter bank results, valid 1 cycle after win_fire
out_valid  out  1  result available
out_ready  in  1  downstream accepts
out_pix  out  8  selected result
out_sof  out  1  result is pixel (0,0)
out_eol  out  1  result is last pixel of a line
out_eof  out  1  result is last pixel of the frame

Behaviour:
- Clock clk; reset rst is synchronous and active-high.
- Reset clears col, row, stage-1 valid (v1), all FIFO entries, and pointers. After reset: out_valid=0, in_ready=1, win_fire=0.
- Accept: beat accepted when in_valid && in_ready. win_fire is combinational and equals that term.
- Coordinates (col 0..IMG_W-1, row 0..IMG_H-1):
  - Tag each accepted beat with its current coordinates, then advance.
  - col wraps to 0 at IMG_W-1 and row increments; at (IMG_W-1, IMG_H-1) both wrap to 0.
  - If in_sof=1 on an accepted beat, the beat is tagged (0,0) regardless of counters, and counters continue from (1,0) (resync).
  - in_sof on a non-accepted cycle is ignored.
- Stage 1 (one cycle after accept): v1=1. Registered copies of edge code, centre pixel, border flag, sof/eol/eof flags.
  - border = row==0 | row==IMG_H-1 | col==0 | col==IMG_W-1.
  - Selected pixel = stage-1 centre if border, else p{edge}_res.
  - Push {pix, sof, eol, eof} into the output FIFO when v1=1.
- Output FIFO: 3 entries, 11 bits wide.
  - out_valid = count!=0; outputs drive head entry.
  - Pop on out_valid && out_ready. Push and pop may occur in the same cycle (count unchanged).
- Credit rule: in_ready = (count + v1) < 3, computed from registers only (no combinational path from out_ready).
  - This guarantees push never overflows.
  - Sustained 1 beat/cycle with out_ready=1 (steady state count=1, v1=1).
- Order preserved; results never dropped or duplicated.
- Latency: accept at cycle N -> out_valid at N+2 if FIFO empty and out_ready=1.
- Out-of-range IMG_W/IMG_H: not supported; no checking.

Decomposition:
- Package te_pkg:
  - edge code constants EDGE_NONE=0, EDGE_H=1, EDGE_D=2, EDGE_V=3
  - localparam OUT_FIFO_DEPTH=3
  - result-entry field widths
- One sub-module, te_out_fifo: 3-entry synchronous FIFO with count output and simultaneous push/pop.
- Coordinate counters and the border/select mux stay in te_filter_sched.

Test Plan:
- Interior pixel: IMG_W=IMG_H=4, stream a full frame, out_ready=1. Pixel (1,1) with edge=2 and p2_res=0x5A -> out_pix=0x5A at 2 cycles after its accept.
- Border bypass: pixel (0,0) with in_center=0x33, edge=1, p1_res=0x99 -> out_pix=0x33 with out_sof=1. Pixel (3,3) -> out_eof=1; every col-3 pixel -> out_eol=1.
- Backpressure: out_ready=0 with continuous in_valid -> in_ready drops after at most 3 accepts, 3 results are held, no win_fire while stalled. Release -> results emerge in order, none lost.
- Throughput: out_ready=1 with a continuous 16-beat frame -> in_ready stays 1, out_valid stays 1 from cycle 2 through cycle 17.
- Resync: in_sof=1 accepted at counter (2,1) -> that result has out_sof=1, and the next beat is tagged (1,0) and treated as border.
- Mid-frame reset: rst for 1 cycle with 2 entries queued -> next cycle out_valid=0, in_ready=1, and the next accepted beat is tagged (0,0).
